interval_stats_mc: RTL
======================

Name: interval_stats_mc

Overview:
- Multi-channel, parametrised interval min/max tracker for the sound-processing datapath.
- Accepts a time-multiplexed stream of signed samples tagged with a channel index and keeps running min, max and sample count per channel.
- On each interval close, atomically snapshots all channels, restarts accumulation and streams one result record per channel over a valid/ready handshake.
- Intervals close on an external pulse or an internal sample counter; the block adds peak-to-peak output and overrun detection.

Parameters:
- DATA_W, 16, sample width (signed two's complement).
- NUM_CH, 4, number of channels (>=1).
- CH_W, $clog2(NUM_CH) (min 1), channel index width.
- CNT_W, 16, per-channel sample-count width (saturating).
- INTERVAL_SAMPLES, 0, accepted samples (all channels) per interval. 0 = external interval_done only.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  sample strobe; no backpressure, always accepted.
- in_ch  in  CH_W  channel of in_sample; values >= NUM_CH are ignored.
- in_sample  in  DATA_W  signed sample.
- interval_done  in  1  single-cycle external interval close.
- out_valid  out  1  result record valid.
- out_ready  in  1  consumer accepts the record.
- out_ch  out  CH_W  channel of the current record.
- out_min  out  DATA_W  signed interval minimum.
- out_max  out  DATA_W  signed interval maximum.
- out_p2p  out  DATA_W+1  unsigned out_max - out_min.
- out_count  out  CNT_W  samples seen on the channel in the interval.
- overrun  out  1  sticky: an interval closed while a drain was in progress.
- clr_overrun  in  1  synchronous clear of overrun.

Behaviour:
- Reset (rst_n=0, async):
  - Every accumulator and every snapshot goes to the empty state: min=SMAX (0x7FFF), max=SMIN (0x8000), count=0.
  - FSM goes to IDLE, interval counter to 0.
  - out_valid=0, out_ch=0, out_min=SMAX, out_max=SMIN, out_p2p=0, out_count=0, overrun=0.
- Accumulate, when in_valid and in_ch<NUM_CH:
  - min[ch] <= sample if sample<min[ch]; max[ch] <= sample if sample>max[ch]. Comparisons are signed.
  - count[ch] increments and saturates at 2^CNT_W-1.
- Close event = interval_done OR (INTERVAL_SAMPLES>0 AND in_valid AND int_cnt==INTERVAL_SAMPLES-1).
  - Coincident sources produce a single close.
  - int_cnt counts every in_valid, including invalid channels, and returns to 0 on any close.
- On close:
  - A sample arriving in the close cycle belongs to the closing interval and is folded into the snapshot.
  - Accumulators reload to empty in the same edge.
- FSM IDLE:
  - On close: load all snapshots, out_ch<=0, out_valid<=1 on the next cycle (latency 1), go to DRAIN.
- FSM DRAIN:
  - Present snapshot[out_ch].
  - On out_valid&&out_ready: if out_ch==NUM_CH-1, out_valid<=0 and go to IDLE; else out_ch++.
  - Output fields stay stable while out_valid&&!out_ready.
- Close during DRAIN (including the final handshake cycle):
  - Snapshots are untouched and the drain continues.
  - Accumulators still restart, so that interval's data is lost.
  - overrun<=1.
- overrun: set has priority over clr_overrun in the same cycle.
- Empty channel (count=0): out_min=SMAX, out_max=SMIN, out_p2p forced to 0.
- out_p2p: computed in DATA_W+1 bits, so it never overflows (0x7FFF - 0x8000 = 0xFFFF).

Decomposition:
- Package interval_stats_pkg: FSM state enum {IDLE, DRAIN}; functions smax(w) and smin(w); a record typedef holding min/max/count.
- Sub-module minmax_acc_ch, one instance per channel:
  - Inputs: sample, update strobe, restart strobe.
  - Outputs: min, max and saturating count.
  - Restart and update in the same cycle produce the folded value at the output and empty state internally.

Test Plan:
- NUM_CH=2, external close: ch0 samples 5,-3,100; ch1 sample -32768; pulse interval_done; out_ready=1 -> records (ch0: min -3, max 100, p2p 103, count 3) then (ch1: -32768, -32768, 0, 1). out_valid rises 1 cycle after the close.
- Backpressure: hold out_ready=0 for 5 cycles after close -> out_valid=1 and fields stable; release -> both records in order, then out_valid=0.
- INTERVAL_SAMPLES=4: feed 4 samples 1,2,3,4 on ch0 -> close on the 4th sample with max=4, count=4. The 5th sample (9) appears only in the next interval.
- Overrun: close, keep out_ready=0, close again -> overrun=1 and the first snapshot is still presented. After pulsing clr_overrun, overrun=0.
- Empty channel plus invalid channel: NUM_CH=3, no samples on ch2, in_ch=3 once -> ch2 record 0x7FFF/0x8000/0/0 and nothing corrupted.
- Reset mid-drain: assert rst_n=0 while out_ch=1 -> out_valid=0 immediately (async) and all outputs at reset values; after release the next interval reports fresh data only.

Source files
------------

// File: rtl/interval_stats_pkg.sv
// Shared types and helpers for the interval min/max tracker: FSM states,
// signed-extreme helpers and the per-channel snapshot record.
package interval_stats_pkg;

    // Widest sample/count width a snapshot record can carry.
    localparam int REC_W = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Fields hold zero-extended bit patterns; users slice back to their width.
    typedef struct packed {
        logic [REC_W-1:0] min_v;
        logic [REC_W-1:0] max_v;
        logic [REC_W-1:0] cnt;
    } stat_rec_t;

    function automatic logic [REC_W-1:0] smax(input int w);
        return (REC_W'(1) << (w - 1)) - REC_W'(1);
    endfunction

    function automatic logic [REC_W-1:0] smin(input int w);
        return REC_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/interval_stats_mc_acc.sv
// One channel's running min/max/count. Outputs already include the sample of
// the current cycle, so a restart in the same cycle still captures it.
module minmax_acc_ch
    import interval_stats_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample,
    input  logic              update,
    input  logic              restart,
    output logic [DATA_W-1:0] min_val,
    output logic [DATA_W-1:0] max_val,
    output logic [CNT_W-1:0]  count
);

    localparam logic [DATA_W-1:0] SMAX = DATA_W'(smax(DATA_W));
    localparam logic [DATA_W-1:0] SMIN = DATA_W'(smin(DATA_W));

    logic [DATA_W-1:0] min_reg;
    logic [DATA_W-1:0] max_reg;
    logic [CNT_W-1:0]  cnt_reg;

    always_comb begin
        min_val = min_reg;
        max_val = max_reg;
        count   = cnt_reg;
        if (update) begin
            if ($signed(sample) < $signed(min_reg)) min_val = sample;
            if ($signed(sample) > $signed(max_reg)) max_val = sample;
            if (cnt_reg != {CNT_W{1'b1}}) count = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_reg <= SMAX;
            max_reg <= SMIN;
            cnt_reg <= '0;
        end else if (restart) begin
            min_reg <= SMAX;
            max_reg <= SMIN;
            cnt_reg <= '0;
        end else begin
            min_reg <= min_val;
            max_reg <= max_val;
            cnt_reg <= count;
        end
    end

endmodule

// File: rtl/interval_stats_mc.sv
// Multi-channel interval min/max tracker: accumulates per-channel statistics,
// snapshots them on interval close and drains one record per channel.
module interval_stats_mc
    import interval_stats_pkg::*;
#(
    parameter int DATA_W           = 16,
    parameter int NUM_CH           = 4,
    parameter int CH_W             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int CNT_W            = 16,
    parameter int INTERVAL_SAMPLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] in_sample,
    input  logic              interval_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [DATA_W-1:0] out_min,
    output logic [DATA_W-1:0] out_max,
    output logic [DATA_W:0]   out_p2p,
    output logic [CNT_W-1:0]  out_count,
    output logic              overrun,
    input  logic              clr_overrun
);

    localparam int               IC_W       = (INTERVAL_SAMPLES > 1) ? $clog2(INTERVAL_SAMPLES) : 1;
    localparam bit               AUTO_CLOSE = (INTERVAL_SAMPLES > 0);
    localparam logic [IC_W-1:0]  IC_LAST    = IC_W'((INTERVAL_SAMPLES > 0) ? INTERVAL_SAMPLES - 1 : 0);
    localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(NUM_CH - 1);
    localparam logic [REC_W-1:0] SMAX_R     = smax(DATA_W);
    localparam logic [REC_W-1:0] SMIN_R     = smin(DATA_W);

    logic [IC_W-1:0]   int_cnt_reg;
    logic              close;
    logic [DATA_W-1:0] acc_min [NUM_CH];
    logic [DATA_W-1:0] acc_max [NUM_CH];
    logic [CNT_W-1:0]  acc_cnt [NUM_CH];
    stat_rec_t         snap_reg [NUM_CH];

    state_t            state_reg, state_next;
    logic [CH_W-1:0]   out_ch_reg, out_ch_next;
    logic              out_valid_reg, out_valid_next;
    logic              overrun_reg, overrun_next;
    logic              load_snap;

    assign close = interval_done || (AUTO_CLOSE && in_valid && (int_cnt_reg == IC_LAST));

    // Counts every strobe, valid channel or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_cnt_reg <= '0;
        end else if (close) begin
            int_cnt_reg <= '0;
        end else if (AUTO_CLOSE && in_valid) begin
            int_cnt_reg <= int_cnt_reg + IC_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            minmax_acc_ch #(
                .DATA_W (DATA_W),
                .CNT_W  (CNT_W)
            ) u_acc (
                .clk     (clk),
                .rst_n   (rst_n),
                .sample  (in_sample),
                .update  (in_valid && (in_ch == CH_W'(gi))),
                .restart (close),
                .min_val (acc_min[gi]),
                .max_val (acc_max[gi]),
                .count   (acc_cnt[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                snap_reg[i] <= '{min_v: SMAX_R, max_v: SMIN_R, cnt: '0};
            end
        end else if (load_snap) begin
            for (int i = 0; i < NUM_CH; i++) begin
                snap_reg[i] <= '{min_v: REC_W'(acc_min[i]),
                                 max_v: REC_W'(acc_max[i]),
                                 cnt:   REC_W'(acc_cnt[i])};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            out_ch_reg    <= '0;
            out_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            out_ch_reg    <= out_ch_next;
            out_valid_reg <= out_valid_next;
            overrun_reg   <= overrun_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        out_ch_next    = out_ch_reg;
        out_valid_next = out_valid_reg;
        overrun_next   = overrun_reg;
        load_snap      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (close) begin
                    load_snap      = 1'b1;
                    out_ch_next    = '0;
                    out_valid_next = 1'b1;
                    state_next     = DRAIN;
                end
            end
            DRAIN: begin
                if (out_valid_reg && out_ready) begin
                    if (out_ch_reg == CH_LAST) begin
                        out_valid_next = 1'b0;
                        state_next     = IDLE;
                    end else begin
                        out_ch_next = out_ch_reg + CH_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // A close that cannot be snapshotted loses its interval; set beats clear.
        if (clr_overrun) overrun_next = 1'b0;
        if (close && (state_reg == DRAIN)) overrun_next = 1'b1;
    end

    stat_rec_t cur_rec;
    logic [DATA_W:0] max_ext, min_ext;

    assign cur_rec   = snap_reg[out_ch_reg];
    assign out_valid = out_valid_reg;
    assign out_ch    = out_ch_reg;
    assign out_min   = cur_rec.min_v[DATA_W-1:0];
    assign out_max   = cur_rec.max_v[DATA_W-1:0];
    assign out_count = cur_rec.cnt[CNT_W-1:0];
    assign overrun   = overrun_reg;
    assign max_ext   = {out_max[DATA_W-1], out_max};
    assign min_ext   = {out_min[DATA_W-1], out_min};
    assign out_p2p   = (out_count == '0) ? '0 : (max_ext - min_ext);

endmodule
